// File: rtl/rpn_stack_ctrl.sv
// Operand-stack controller for the RPN calculator: push/pop of switch values and
// two-operand add/sub/mul/swap on the top two entries via a LOAD/CALC/WB sequence.
module rpn_stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     exec,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     busy,
    output logic                     ovf,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        WB
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    state_e               state_q;
    state_e               state_d;
    op_e                  op_q;

    logic [WIDTH-1:0]     entries [DEPTH];
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   r_q;

    logic [AW-1:0]        idx_top;
    logic [AW-1:0]        idx_nxt;
    logic                 exec_ok;

    logic                 cmd_exec;
    logic                 cmd_push;
    logic                 cmd_pop;
    logic                 load_en;
    logic                 calc_en;
    logic                 wb_en;

    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   calc_r;
    logic                 r_ovf;

    // Indices wrap modulo DEPTH, so count==DEPTH maps its top to entry DEPTH-1.
    assign idx_top = count[AW-1:0] - AW'(1);
    assign idx_nxt = count[AW-1:0] - AW'(2);
    assign exec_ok = (count >= CW'(2));

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign top   = empty ? '0 : entries[idx_top];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (exec && exec_ok) state_d = LOAD;
            LOAD: state_d = CALC;
            CALC: state_d = WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Commands are only decoded in IDLE; exec outranks push, push outranks pop.
    always_comb begin
        busy     = 1'b0;
        cmd_exec = 1'b0;
        cmd_push = 1'b0;
        cmd_pop  = 1'b0;
        load_en  = 1'b0;
        calc_en  = 1'b0;
        wb_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_exec = exec;
                cmd_push = !exec && push;
                cmd_pop  = !exec && !push && pop;
            end
            LOAD: begin
                busy    = 1'b1;
                load_en = 1'b1;
            end
            CALC: begin
                busy    = 1'b1;
                calc_en = 1'b1;
            end
            WB: begin
                busy  = 1'b1;
                wb_en = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------ datapath
    assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};

    // Operands are sign-extended to 2*WIDTH, so the low 2*WIDTH bits of each
    // result are exact for add, sub and mul alike.
    always_comb begin
        calc_r = '0;
        unique case (op_q)
            OP_ADD:  calc_r = b_ext + a_ext;
            OP_SUB:  calc_r = b_ext - a_ext;
            OP_MUL:  calc_r = b_ext * a_ext;
            OP_SWAP: calc_r = '0;
            default: calc_r = '0;
        endcase
    end

    assign r_ovf = (r_q[2*WIDTH-1:WIDTH] != {WIDTH{r_q[WIDTH-1]}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            op_q  <= OP_ADD;
            ovf   <= 1'b0;
            err   <= 1'b0;
            // NOTE: the stack array is explicitly cleared on reset, which forces it
            // into flops rather than a RAM macro; acceptable at this small depth.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (cmd_exec) begin
                if (exec_ok) begin
                    op_q <= op_e'(op);
                    err  <= 1'b0;
                end else begin
                    err  <= 1'b1;
                end
            end

            if (cmd_push) begin
                if (!full) begin
                    entries[count[AW-1:0]] <= din;
                    count <= count + CW'(1);
                    err   <= 1'b0;
                    ovf   <= 1'b0;
                end else begin
                    err   <= 1'b1;
                end
            end

            if (cmd_pop) begin
                if (!empty) begin
                    count <= count - CW'(1);
                    err   <= 1'b0;
                    ovf   <= 1'b0;
                end else begin
                    err   <= 1'b1;
                end
            end

            if (load_en) begin
                a_q <= entries[idx_top];
                b_q <= entries[idx_nxt];
            end

            if (calc_en) begin
                r_q <= calc_r;
            end

            if (wb_en) begin
                if (op_q == OP_SWAP) begin
                    entries[idx_nxt] <= a_q;
                    entries[idx_top] <= b_q;
                    ovf <= 1'b0;
                end else begin
                    entries[idx_nxt] <= r_q[WIDTH-1:0];
                    count <= count - CW'(1);
                    ovf   <= r_ovf;
                end
            end
        end
    end

endmodule
